// File: rtl/interrupt_request_register_if.sv
// Request-side bus of the PIC IR front end: raw lines, trigger mode, mask,
// acknowledge-clear strobe and the latched/masked request outputs.
interface interrupt_request_register_if;
    logic [7:0] ir;
    logic       ltim;
    logic       init;
    logic [7:0] imr;
    logic       ack_clr;
    logic [7:0] ack_bit;
    logic [7:0] irr_raw;
    logic [7:0] irr;
    logic       any_req;

    modport master (
        output ir, ltim, init, imr, ack_clr, ack_bit,
        input  irr_raw, irr, any_req
    );

    modport slave (
        input  ir, ltim, init, imr, ack_clr, ack_bit,
        output irr_raw, irr, any_req
    );
endinterface

// File: rtl/interrupt_request_register.sv
// PIC interrupt request register: synchronises IR0..IR7, applies edge/level
// trigger rules and holds requests until cleared. Optional IRR_GLITCH_FILTER_EN.
module interrupt_request_register #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    interrupt_request_register_if.slave   bus
);

`ifdef IRR_GLITCH_FILTER_EN
    // One extra stage so two consecutive synchronised samples are visible at once.
    localparam int CHAIN = SYNC_STAGES + 1;
`else
    localparam int CHAIN = SYNC_STAGES;
`endif

    logic [CHAIN-1:0][7:0] sync_r;
    logic [CHAIN-1:0]      fill_r;
    logic [7:0]            p_r;
    logic [7:0]            arm_r;
    logic [7:0]            irr_raw_r;

    logic       valid_s;
    logic [7:0] s_s;
    logic [7:0] set_s;
    logic [7:0] clr_s;
    logic [7:0] hold_s;
    logic [7:0] low_s;
    logic [7:0] p_nxt_s;
    logic [7:0] arm_nxt_s;
    logic [7:0] irr_raw_nxt_s;

    // Synchroniser chain plus a fill tracker; reset-value zeros are not real low samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
            fill_r <= '0;
        end else begin
            sync_r <= {sync_r[CHAIN-2:0], bus.ir};
            fill_r <= {fill_r[CHAIN-2:0], 1'b1};
        end
    end

    assign valid_s = fill_r[CHAIN-1];

`ifdef IRR_GLITCH_FILTER_EN
    logic [7:0] filt_r;
    logic [7:0] samp_a_s;
    logic [7:0] samp_b_s;

    assign samp_a_s = sync_r[SYNC_STAGES-1];
    assign samp_b_s = sync_r[SYNC_STAGES];
    assign s_s      = (samp_a_s & samp_b_s) | (filt_r & (samp_a_s ^ samp_b_s));

    // Filter memory: keeps the last agreed value while the two samples disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_r <= 8'h00;
        end else begin
            filt_r <= s_s;
        end
    end
`else
    assign s_s = sync_r[CHAIN-1];
`endif

    // Next-state for previous sample, arm flags and latched requests.
    always_comb begin
        set_s         = arm_r & ~p_r & s_s;
        clr_s         = 8'h00;
        hold_s        = 8'h00;
        low_s         = 8'h00;
        p_nxt_s       = p_r;
        arm_nxt_s     = arm_r;
        irr_raw_nxt_s = irr_raw_r;

        if (bus.ack_clr) begin
            clr_s = bus.ack_bit;
        end else begin
            clr_s = 8'h00;
        end

        if (bus.ltim) begin
            hold_s = s_s;
        end else begin
            hold_s = (irr_raw_r & s_s) | set_s;
        end

        if (valid_s) begin
            low_s = ~s_s;
        end else begin
            low_s = 8'h00;
        end

        if (bus.init) begin
            p_nxt_s       = 8'h00;
            arm_nxt_s     = 8'h00;
            irr_raw_nxt_s = 8'h00;
        end else begin
            p_nxt_s       = s_s;
            // An acked edge counts as consumed, so the arm flag drops with it.
            arm_nxt_s     = (arm_r & ~set_s & ~clr_s) | low_s;
            irr_raw_nxt_s = hold_s & ~clr_s;
        end
    end

    // Per-line state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_r       <= 8'h00;
            arm_r     <= 8'h00;
            irr_raw_r <= 8'h00;
        end else begin
            p_r       <= p_nxt_s;
            arm_r     <= arm_nxt_s;
            irr_raw_r <= irr_raw_nxt_s;
        end
    end

    assign bus.irr_raw = irr_raw_r;
    assign bus.irr     = irr_raw_r & ~bus.imr;
    assign bus.any_req = |(irr_raw_r & ~bus.imr);

endmodule

// File: tb/tb_interrupt_request_register.sv
// Directed self-checking bench for interrupt_request_register (SYNC_STAGES=2).
module tb_interrupt_request_register;

    localparam int SYNC_STAGES = 2;
`ifdef IRR_GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + 2;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    interrupt_request_register_if bus ();

    interrupt_request_register #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.ir      = 8'h00;
        bus.ltim    = 1'b0;
        bus.init    = 1'b0;
        bus.imr     = 8'h00;
        bus.ack_clr = 1'b0;
        bus.ack_bit = 8'h00;

        step(2);
        chk8("reset_irr_raw", bus.irr_raw, 8'h00);
        chk8("reset_irr", bus.irr, 8'h00);
        chk1("reset_any_req", bus.any_req, 1'b0);
        reset = 1'b0;

        // Edge latch on IR3: exactly LAT edges after the rise.
        step(4);
        bus.ir = 8'h08;
        step(LAT - 1);
        chk8("edge_early", bus.irr, 8'h00);
        step(1);
        chk8("edge_latch_irr", bus.irr, 8'h08);
        chk1("edge_latch_any", bus.any_req, 1'b1);

        // Acknowledge while IR3 stays high: no re-request.
        bus.ack_clr = 1'b1;
        bus.ack_bit = 8'h08;
        step(1);
        bus.ack_clr = 1'b0;
        bus.ack_bit = 8'h00;
        chk8("ack_clear", bus.irr, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk8("ack_stays_clear", bus.irr, 8'h00);
        end

        // Level mode re-request.
        bus.ltim = 1'b1;
        bus.ir   = 8'h81;
        step(LAT + 1);
        chk8("level_follow", bus.irr_raw, 8'h81);
        bus.ack_clr = 1'b1;
        bus.ack_bit = 8'h01;
        step(1);
        bus.ack_clr = 1'b0;
        bus.ack_bit = 8'h00;
        chk8("level_ack_gap", bus.irr_raw, 8'h80);
        step(1);
        chk8("level_rerequest", bus.irr_raw, 8'h81);

        // Masking is output-only.
        bus.ltim = 1'b0;
        bus.ir   = 8'h00;
        bus.imr  = 8'h04;
        step(LAT + 1);
        chk8("edge_drop_clear", bus.irr_raw, 8'h00);
        bus.ir = 8'h04;
        step(LAT);
        chk8("mask_raw", bus.irr_raw, 8'h04);
        chk8("mask_irr", bus.irr, 8'h00);
        chk1("mask_any", bus.any_req, 1'b0);
        bus.imr = 8'h00;
        #1;
        chk8("unmask_irr", bus.irr, 8'h04);
        chk1("unmask_any", bus.any_req, 1'b1);

        // Ack on IR5 collides with its rising edge: edge is lost.
        bus.ir = 8'h24;
        step(LAT - 1);
        bus.ack_clr = 1'b1;
        bus.ack_bit = 8'h20;
        step(1);
        bus.ack_clr = 1'b0;
        bus.ack_bit = 8'h00;
        chk8("collide_raw", bus.irr_raw, 8'h04);
        step(3);
        chk8("collide_lost", bus.irr_raw, 8'h04);

        // Init with all lines high.
        bus.ir = 8'hFF;
        step(LAT + 1);
        chk8("pre_init_raw", bus.irr_raw, 8'hDF);
        bus.init = 1'b1;
        step(1);
        bus.init = 1'b0;
        chk8("init_clear", bus.irr_raw, 8'h00);
        step(5);
        chk8("init_no_rereq", bus.irr_raw, 8'h00);
        bus.ir = 8'h00;
        step(LAT + 1);
        bus.ir = 8'hFF;
        step(LAT);
        chk8("init_new_edges", bus.irr_raw, 8'hFF);

        // Asynchronous reset mid-operation.
        bus.ir = 8'h3C;
        step(LAT);
        chk8("pre_reset_raw", bus.irr_raw, 8'h3C);
        #2;
        reset = 1'b1;
        #1;
        chk8("async_reset_raw", bus.irr_raw, 8'h00);
        chk8("async_reset_irr", bus.irr, 8'h00);
        chk1("async_reset_any", bus.any_req, 1'b0);
        bus.ir = 8'hFF;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk8("reset_high_no_req", bus.irr_raw, 8'h00);
        end

`ifdef IRR_GLITCH_FILTER_EN
        // One-cycle pulse is filtered; a three-cycle pulse latches.
        bus.ir = 8'h00;
        step(LAT + 2);
        bus.ir = 8'h01;
        step(1);
        bus.ir = 8'h00;
        step(8);
        chk8("filter_short_pulse", bus.irr_raw, 8'h00);
        bus.ir = 8'h01;
        step(3);
        bus.ir = 8'h00;
        chk8("filter_long_early", bus.irr_raw, 8'h00);
        step(1);
        chk8("filter_long_latch", bus.irr_raw, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_request_register.md
# interrupt_request_register

Front-end request stage of the PIC: samples the eight raw IR lines, synchronises them to `clk`, applies edge- or level-trigger rules and holds pending requests until the priority resolver grants one. Sits directly upstream of the priority resolver. Drives its `irr` input and consumes its `reset_irr_bit` / `irr_highest_bit` outputs as the per-bit clear.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth per IR line. Legal values are 2..4.
- `clk` in 1: single system clock. Every register is on its rising edge.
- `reset` in 1: asynchronous, active-high. Clears every register.
- `ir` in 8: raw asynchronous request lines IR0..IR7.
- `ltim` in 1: trigger mode from ICW1. 1 = level, 0 = edge.
- `init` in 1: one-cycle pulse on an ICW1 write.
- `imr` in 8: interrupt mask register. 1 = masked.
- `ack_clr` in 1: clear strobe (resolver `reset_irr_bit`).
- `ack_bit` in 8: one-hot bit to clear (resolver `irr_highest_bit`).
- `irr_raw` out 8: latched requests before masking. Read back through OCW3.
- `irr` out 8: `irr_raw & ~imr`. Goes to the resolver.
- `any_req` out 1: OR-reduction of `irr`.

## Operation
- Per line n, the chain is: synchroniser `s[n]` → previous sample `p[n]` → arm flag `arm[n]` → latch `irr_raw[n]`.
- `arm[n]` sets in any cycle where `s[n]`=0. It clears when the edge is consumed (latch set, or clear-on-ack), and on `init`.
- Edge mode (`ltim`=0):
  - `irr_raw[n]` sets when `arm[n]` && `p[n]`=0 && `s[n]`=1.
  - It stays set while `s[n]`=1.
  - It clears when `s[n]` falls to 0 before acknowledge. This withdraws the request; no latch survives a dropped line.
  - After an acknowledge the bit stays 0 until the line has been low at least one sampled cycle and then rises again.
- Level mode (`ltim`=1):
  - `irr_raw[n]` follows `s[n]`.
  - On `ack_clr` the bit is 0 for exactly one cycle, then re-follows `s[n]`. A line still high re-requests.
- Clear-on-ack: when `ack_clr`=1, every bit n with `ack_bit[n]`=1 clears. If `ack_bit` is not one-hot, all indicated bits clear. `ack_bit`=0 is a no-op.
- `init`=1 clears `irr_raw`, `arm` and `p`. Synchronisers keep running. After init, an edge-mode line that is already high raises no request until it goes low and then high.
- Masking is output-only. A masked bit still latches into `irr_raw`, and it appears on `irr` as soon as `imr[n]` goes to 0.
- Simultaneous events, in priority order:
  1. `reset`
  2. `init`
  3. `ack_clr` on bit n (beats a new edge on n in the same cycle; that edge is consumed and lost)
  4. set
- Changing `ltim` mid-operation takes effect next cycle. Latched bits are then re-evaluated under the new mode's hold rule.
- Reset values:
  - `irr_raw`=0, `irr`=0, `any_req`=0.
  - Synchronisers, `p` and `arm` are all 0.
  - A line held high through reset gives no edge-mode request until it has been seen low.

## Timing
- From an `ir[n]` rise to `irr_raw[n]`: SYNC_STAGES+1 clk edges, plus 1 when the filter below is compiled in.
- From an `ir[n]` fall to the clear: same latency.
- `ack_clr` sampled at edge k: the bit reads 0 after edge k.
- `irr`, `any_req`: combinational from `irr_raw` and `imr`. No added latency, and no glitches on `imr` changes beyond the AND.
- Asserting `reset` clears outputs immediately, without a clock. Deassertion takes effect at the next `clk` edge.

## Configuration
- `IRR_GLITCH_FILTER_EN`
  - Defined: each synchronised line passes through a 2-sample agreement filter. The filtered value changes only when two consecutive synchronised samples agree. This adds 1 cycle latency, and a pulse of one sampled cycle is ignored in both modes.
  - Undefined: no filter. A single sampled high cycle after a sampled low latches an edge request.

## Test plan
- Edge latch, SYNC_STAGES=2, no filter, `ltim`=0, `imr`=0. Hold `ir`=0 for 4 cycles, then `ir[3]`=1 → `irr`=8'h08 and `any_req`=1 after exactly 3 edges. `ack_clr`=1 with `ack_bit`=8'h08 while `ir[3]` stays high → `irr`=0 next cycle and stays 0 for 10 cycles.
- Level re-request, `ltim`=1, `ir`=8'h81 held. `ack_clr` with `ack_bit`=8'h01 → `irr_raw`=8'h80 for one cycle, then 8'h81.
- Mask, `imr`=8'h04, edge on IR2 → `irr_raw`=8'h04, `irr`=0, `any_req`=0. Set `imr`=0 → `irr`=8'h04 in the same cycle.
- Collision and init:
  - A rising edge on IR5 in the same cycle as `ack_clr` with `ack_bit`=8'h20 → `irr_raw[5]`=0 and the edge is lost.
  - `init` pulse with `ir`=8'hFF held → `irr_raw`=0 until the lines go low and then high.
- Reset mid-operation, `irr_raw`=8'h3C: assert `reset` between clock edges → all outputs 0 immediately. Release with `ir`=8'hFF held in edge mode → no request.
- With `IRR_GLITCH_FILTER_EN`:
  - A one-cycle `ir[0]` pulse aligned to `clk` → `irr_raw` stays 0.
  - A 3-cycle pulse → `irr_raw[0]`=1 after SYNC_STAGES+2 edges.
